// File: rtl/prim_subreg_ext_hs_if.sv
// Handshake bundle for one external register field: software-side strobes and
// completion, plus the held request/acknowledge pair toward the hardware agent.
interface prim_subreg_ext_hs_if #(
  parameter int DW = 32
);
  // software side
  logic          re;
  logic          we;
  logic [DW-1:0] wd;
  logic          busy;
  logic          ready;
  logic          err;
  logic [DW-1:0] qs;
  // hardware side
  logic          req;
  logic          wr;
  logic [DW-1:0] q;
  logic          ack;
  logic [DW-1:0] d;

  // View of the register slice itself.
  modport slave (
    input  re, we, wd, ack, d,
    output busy, ready, err, qs, req, wr, q
  );

  // View of the surrounding decode logic and hardware agent.
  modport master (
    output re, we, wd, ack, d,
    input  busy, ready, err, qs, req, wr, q
  );
endinterface

// File: rtl/prim_subreg_ext_hs.sv
// Handshaked external register slice. A software strobe becomes a held request
// to hardware; the slice waits for ack (or a bounded timeout) and returns a
// one-cycle ready/err completion with the read-back value in qs.
module prim_subreg_ext_hs #(
  parameter int            DW      = 32,
  parameter int            TIMEOUT = 16,
  parameter logic [DW-1:0] RESVAL  = '0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  prim_subreg_ext_hs_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e        state;
  logic          wr_q;
  logic [DW-1:0] q_q;
  logic [DW-1:0] qs_q;
  logic          ready_q;
  logic          err_q;
  logic          timeout_hit;

  if (TIMEOUT > 0) begin : g_timeout
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    // Count BUSY cycles without ack; held at zero while idle so every access starts fresh.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt <= '0;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else if (!bus.ack) begin
        cnt <= cnt + CW'(1);
      end
    end

    // An ack in the final cycle takes priority, so the abort needs ack low.
    assign timeout_hit = (state == BUSY) && !bus.ack && (cnt == CW'(TIMEOUT - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  // Access FSM: latch the access on a strobe, complete on ack or timeout.
  // NOTE: non-blocking assignments here so every flop sees pre-edge values; the
  // ready/err defaults at the top make them single-cycle pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      q_q     <= RESVAL;
      qs_q    <= RESVAL;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          // Write wins over a simultaneous read; the read is dropped.
          if (bus.we) begin
            q_q   <= bus.wd;
            wr_q  <= 1'b1;
            state <= BUSY;
          end else if (bus.re) begin
            wr_q  <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Strobes are ignored here; q and wr stay stable for the agent.
          if (bus.ack) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            qs_q    <= wr_q ? q_q : bus.d;
          end else if (timeout_hit) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state == BUSY);
  assign bus.req   = (state == BUSY);
  assign bus.wr    = wr_q;
  assign bus.q     = q_q;
  assign bus.qs    = qs_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;

endmodule
